ysyx_25020037_ifu: RTL

Instruction fetch unit of the multi-cycle NPC; sits directly upstream of the instruction decoder. Holds the architectural fetch PC, issues one read per instruction on an AXI4-Lite-style read channel, and presents the fetched word with its PC to decode over a valid/ready handshake. It then waits for the commit of the next PC from the execute/writeback path before fetching again.

---
 rtl/ysyx_25020037_pkg.sv | 19 +
 rtl/ysyx_25020037_reg.sv | 29 ++
 rtl/ysyx_25020037_ifu.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25020037_pkg.sv
// ysyx_25020037_pkg
//   Shared definitions for the NPC front end: the IFU state encoding, the
//   AXI read-response code for OKAY, the default reset fetch address and the
//   canonical NOP encoding (addi x0, x0, 0).
package ysyx_25020037_pkg;

    typedef enum logic [2:0] {
        IFU_ADDR = 3'd0,
        IFU_DATA = 3'd1,
        IFU_OUT  = 3'd2,
        IFU_WAIT = 3'd3,
        IFU_HALT = 3'd4
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_25020037_reg.sv
// ysyx_25020037_reg
//   Parameterised-width D flip-flop with load enable, asynchronous
//   active-low reset and a configurable reset value.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset, loads RST_VAL
//     en     in   load enable
//     d      in   next value (WIDTH bits)
//     q      out  registered value (WIDTH bits)
module ysyx_25020037_reg #(
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_25020037_ifu.sv
// ysyx_25020037_ifu
//   Instruction fetch unit of the multi-cycle NPC. Holds the fetch PC, issues
//   one AXI4-Lite-style read per instruction, hands the fetched word and its
//   PC to decode over valid/ready, then waits for the next PC to be committed.
//
//   Ports:
//     clk, rst_n                      clock / async active-low reset
//     araddr, arvalid, arready        read address channel (IFU is master)
//     rdata, rresp, rvalid, rready    read data channel
//     inst, inst_pc, inst_valid,
//     inst_ready                      instruction output to decode
//     commit_valid, commit_pc         next PC from execute/writeback
//     exec_halt                       ebreak retired: stop fetching
//     fetch_fault                     sticky: non-OKAY read response
//     fetch_misalign                  sticky: misaligned commit_pc
//
//   Build option:
//     YSYX_25020037_IFU_MISALIGN_CHK_EN  when defined, a commit_pc with
//       nonzero low bits halts the IFU and sets fetch_misalign. When not
//       defined, the low bits are cleared and fetch_misalign is constant 0.
module ysyx_25020037_ifu
    import ysyx_25020037_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        exec_halt,
    output logic        fetch_fault,
    output logic        fetch_misalign
);

    logic [2:0]  state_q;
    ifu_state_t  state;
    ifu_state_t  state_n;

    logic [31:0] pc_q;
    logic        pc_en;
    logic        inst_en;

    logic        arvalid_q;
    logic        rready_q;
    logic        inst_valid_q;
    logic        fault_q;
    logic        halt_pend_q;

    logic        set_fault;
    logic        set_halt_pend;
    logic        set_misalign;
    logic        take_commit;
    logic        commit_bad;
    logic [31:0] commit_pc_eff;

    assign state = ifu_state_t'(state_q);

`ifdef YSYX_25020037_IFU_MISALIGN_CHK_EN
    assign commit_bad    = (commit_pc[1:0] != 2'b00);
    assign commit_pc_eff = commit_pc;
`else
    logic unused_nochk;
    assign commit_bad    = 1'b0;
    assign commit_pc_eff = {commit_pc[31:2], 2'b00};
    assign unused_nochk  = ^{commit_pc[1:0], set_misalign};
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        pc_en         = 1'b0;
        inst_en       = 1'b0;
        set_fault     = 1'b0;
        set_halt_pend = 1'b0;
        set_misalign  = 1'b0;
        take_commit   = 1'b0;

        case (state)
            IFU_ADDR: begin
                // arvalid cannot be withdrawn once raised, so a halt here is
                // remembered and honoured when the data beat returns.
                set_halt_pend = exec_halt;
                if (arvalid_q && arready) begin
                    state_n = IFU_DATA;
                end
            end
            IFU_DATA: begin
                set_halt_pend = exec_halt;
                if (rready_q && rvalid) begin
                    if (rresp != RESP_OKAY) begin
                        set_fault = 1'b1;
                        state_n   = IFU_HALT;
                    end else if (halt_pend_q || exec_halt) begin
                        state_n = IFU_HALT;
                    end else begin
                        inst_en = 1'b1;
                        state_n = IFU_OUT;
                    end
                end
            end
            IFU_OUT: begin
                if (exec_halt) begin
                    state_n = IFU_HALT;
                end else if (inst_valid_q && inst_ready) begin
                    if (commit_valid) begin
                        take_commit = 1'b1;
                    end else begin
                        state_n = IFU_WAIT;
                    end
                end
            end
            IFU_WAIT: begin
                if (exec_halt) begin
                    state_n = IFU_HALT;
                end else if (commit_valid) begin
                    take_commit = 1'b1;
                end
            end
            IFU_HALT: begin
                state_n = IFU_HALT;
            end
            default: begin
                state_n = IFU_HALT;
            end
        endcase

        if (take_commit) begin
            if (commit_bad) begin
                set_misalign = 1'b1;
                state_n      = IFU_HALT;
            end else begin
                pc_en   = 1'b1;
                state_n = IFU_ADDR;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    ysyx_25020037_reg #(.WIDTH(3), .RST_VAL(IFU_ADDR)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (state_n),
        .q     (state_q)
    );

    ysyx_25020037_reg #(.WIDTH(32), .RST_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_en),
        .d     (commit_pc_eff),
        .q     (pc_q)
    );

    ysyx_25020037_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_inst (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (inst_en),
        .d     (rdata),
        .q     (inst)
    );

    ysyx_25020037_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_inst_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (inst_en),
        .d     (pc_q),
        .q     (inst_pc)
    );

    // Handshake outputs are registered copies of the next-state decode, so
    // they track the state yet stay low during reset (state resets to ADDR
    // but arvalid must only rise on the first cycle after reset release).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            halt_pend_q  <= 1'b0;
        end else begin
            arvalid_q    <= (state_n == IFU_ADDR);
            rready_q     <= (state_n == IFU_DATA);
            inst_valid_q <= (state_n == IFU_OUT);
            fault_q      <= fault_q | set_fault;
            halt_pend_q  <= halt_pend_q | set_halt_pend;
        end
    end

`ifdef YSYX_25020037_IFU_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_q | set_misalign;
        end
    end

    assign fetch_misalign = misalign_q;
`else
    assign fetch_misalign = 1'b0;
`endif

    assign araddr      = pc_q;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign inst_valid  = inst_valid_q;
    assign fetch_fault = fault_q;

endmodule
